uart_simplex_parity: RTL and testbench

Self-contained simplex UART link: a transmitter serialises an 8-bit parallel word into an asynchronous-style frame (start, 8 data LSB-first, parity, stop) on an internal serial line, and a receiver on the same clock deserialises it back to a parallel word. It is used as a loopback/protocol building block and reference for serial links elsewhere in the design. A one-cycle `done` pulse marks each validated received word.

---
 rtl/uart_simplex_parity_if.sv | 12 +
 rtl/uart_simplex_parity.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_simplex_parity.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_simplex_parity_if.sv
// Handshake/data bundle for uart_simplex_parity: frame request, abort, TX word in,
// and RX word out with its one-cycle done pulse.
interface uart_simplex_parity_if;
    logic       start;
    logic       stop;
    logic [7:0] din;
    logic [7:0] dout;
    logic       done;

    modport master (output start, output stop, output din, input dout, input done);
    modport slave  (input start, input stop, input din, output dout, output done);
endinterface

// File: rtl/uart_simplex_parity.sv
// Simplex UART loopback: TX serialises din onto an internal line, RX deserialises it in lockstep.
// Optional parity bit selected by macro UART_PARITY_EN (undefined: 10-bit frame, no parity).
module uart_simplex_parity #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    uart_simplex_parity_if.slave  bus
);
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
`ifdef UART_PARITY_EN
        RX_PARITY = 2'd2,
`endif
        RX_STOP   = 2'd3
    } rx_state_e;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
    function automatic logic parity_of(input logic [7:0] b);
        return (^b) ^ PARITY_ODD;
    endfunction
`endif

    tx_state_e   tx_state_q, tx_state_d;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        line_q, line_d;
    logic [7:0]  dout_q, dout_d;
    logic        done_q, done_d;
`ifdef UART_PARITY_EN
    logic        tx_par_q, tx_par_d;
    logic        rx_par_ok_q, rx_par_ok_d;
`endif
    logic        bit_end_s;
    logic        rx_sample_s;

    // RX samples on the last cycle of every bit period driven by the shared TX counter
    assign bit_end_s   = (cnt_q == LAST_CNT);
    assign rx_sample_s = bit_end_s && (tx_state_q != TX_IDLE);

    assign bus.dout = dout_q;
    assign bus.done = done_q;

    // TX next state, bit counter and serial line
    always_comb begin
        tx_state_d = tx_state_q;
        cnt_d      = cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        line_d     = line_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (bus.stop) begin
            tx_state_d = TX_IDLE;
            cnt_d      = 16'd0;
            tx_idx_d   = 3'd0;
            line_d     = 1'b1;
        end else if (tx_state_q == TX_IDLE) begin
            cnt_d  = 16'd0;
            line_d = 1'b1;
            if (!bus.start) begin
                tx_shift_d = bus.din;
`ifdef UART_PARITY_EN
                tx_par_d   = parity_of(bus.din);
`endif
                tx_idx_d   = 3'd0;
                line_d     = 1'b0;
                tx_state_d = TX_START;
            end else begin
                tx_state_d = TX_IDLE;
            end
        end else if (!bit_end_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
            case (tx_state_q)
                TX_START: begin
                    tx_state_d = TX_DATA;
                    line_d     = tx_shift_q[0];
                end
                TX_DATA: begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_idx_d   = tx_idx_q + 3'd1;
                    if (tx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        line_d     = tx_par_q;
`else
                        tx_state_d = TX_STOP;
                        line_d     = 1'b1;
`endif
                    end else begin
                        line_d = tx_shift_q[1];
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    tx_state_d = TX_STOP;
                    line_d     = 1'b1;
                end
`endif
                TX_STOP: begin
                    tx_state_d = TX_IDLE;
                    line_d     = 1'b1;
                end
                default: begin
                    tx_state_d = TX_IDLE;
                    line_d     = 1'b1;
                end
            endcase
        end
    end

    // RX next state, word assembly and done/dout update
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        dout_d      = dout_q;
        done_d      = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_ok_d = rx_par_ok_q;
`endif
        if (bus.stop) begin
            rx_state_d = RX_IDLE;
            rx_idx_d   = 3'd0;
        end else if (rx_sample_s) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!line_q) begin
                        rx_state_d = RX_DATA;
                        rx_idx_d   = 3'd0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    rx_shift_d = {line_q, rx_shift_q[7:1]};
                    rx_idx_d   = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    rx_par_ok_d = (line_q == parity_of(rx_shift_q));
                    rx_state_d  = RX_STOP;
                end
`endif
                RX_STOP: begin
`ifdef UART_PARITY_EN
                    if (line_q && rx_par_ok_q) begin
`else
                    if (line_q) begin
`endif
                        dout_d = rx_shift_q;
                        done_d = 1'b1;
                    end else begin
                        dout_d = dout_q;
                    end
                    rx_state_d = RX_IDLE;
                end
                default: begin
                    rx_state_d = RX_IDLE;
                end
            endcase
        end else begin
            rx_state_d = rx_state_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            rx_state_q  <= RX_IDLE;
            cnt_q       <= 16'd0;
            tx_idx_q    <= 3'd0;
            rx_idx_q    <= 3'd0;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 8'h00;
            line_q      <= 1'b1;
            dout_q      <= 8'h00;
            done_q      <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q    <= 1'b0;
            rx_par_ok_q <= 1'b0;
`endif
        end else begin
            tx_state_q  <= tx_state_d;
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            tx_idx_q    <= tx_idx_d;
            rx_idx_q    <= rx_idx_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            line_q      <= line_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
`ifdef UART_PARITY_EN
            tx_par_q    <= tx_par_d;
            rx_par_ok_q <= rx_par_ok_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_simplex_parity.sv
// Scoreboard bench for uart_simplex_parity: one instance at 1 clock/bit even parity,
// one at 4 clocks/bit odd parity; expected words queued at launch, popped on done.
`timescale 1ns/1ps
module tb_uart_simplex_parity;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [7:0] sb_q[$];

    uart_simplex_parity_if if1();
    uart_simplex_parity_if if4();

    uart_simplex_parity #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    uart_simplex_parity #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut4 (
        .clk(clk), .rst(rst), .bus(if4.slave));

    always #5 clk = ~clk;

    // Expected serial line value during bit slot k of a frame carrying d
    function automatic logic exp_line_bit(input logic [7:0] d, input int k, input bit odd);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (FRAME_BITS == 11 && k == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done on the selected instance; cycles=-1 when the bound expires
    task automatic wait_done(input int sel, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((sel == 1 && if1.done === 1'b1) || (sel == 4 && if4.done === 1'b1)) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if1.start = 1'b1; if1.stop = 1'b0; if1.din = 8'h00;
        if4.start = 1'b1; if4.stop = 1'b0; if4.din = 8'h00;
        tick();
        rst = 1'b0;
        n_checks++;
        if (if1.dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", if1.dout); else n_pass++;
        n_checks++;
        if (if1.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", if1.done); else n_pass++;
        n_checks++;
        if (dut1.line_q !== 1'b1) $display("FAIL reset_line: got %b expected 1", dut1.line_q); else n_pass++;
        n_checks++;
        if (if4.dout !== 8'h00) $display("FAIL reset_dout4: got %h expected 00", if4.dout); else n_pass++;
    endtask

    task automatic test_single();
        logic [7:0] d = 8'h81;
        logic [7:0] exp;
        logic       obs[16];
        bit         early = 1'b0;
        int         c;
        if1.din = d; if1.start = 1'b0;
        sb_q.push_back(d);
        tick();
        if1.start = 1'b1;
        obs[0] = dut1.line_q;
        for (int k = 1; k < FRAME_BITS; k++) begin
            tick();
            obs[k] = dut1.line_q;
            if (if1.done === 1'b1) early = 1'b1;
        end
        for (int k = 0; k < FRAME_BITS; k++) begin
            n_checks++;
            if (obs[k] !== exp_line_bit(d, k, 1'b0))
                $display("FAIL single_line bit %0d: got %b expected %b", k, obs[k], exp_line_bit(d, k, 1'b0));
            else n_pass++;
        end
        n_checks++;
        if (early) $display("FAIL single_early_done: got done before frame end expected none"); else n_pass++;
        wait_done(1, 20, c);
        n_checks++;
        if (c < 0 || (FRAME_BITS - 1 + c) !== FRAME_BITS)
            $display("FAIL single_latency: got %0d expected %0d", (c < 0) ? -1 : FRAME_BITS - 1 + c, FRAME_BITS);
        else n_pass++;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        n_checks++;
        if (if1.dout !== exp) $display("FAIL single_dout: got %h expected %h", if1.dout, exp); else n_pass++;
        tick();
        n_checks++;
        if (if1.done !== 1'b0) $display("FAIL single_done_width: got %b expected 0", if1.done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        int         c;
        if1.din = 8'hA5; if1.start = 1'b0;
        sb_q.push_back(8'hA5);
        sb_q.push_back(8'h3C);
        tick();
        if1.din = 8'h3C;
        wait_done(1, 40, c);
        n_checks++;
        if (c !== FRAME_BITS) $display("FAIL b2b_first_latency: got %0d expected %0d", c, FRAME_BITS); else n_pass++;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        n_checks++;
        if (if1.dout !== exp) $display("FAIL b2b_first_dout: got %h expected %h", if1.dout, exp); else n_pass++;
        wait_done(1, 40, c);
        if1.start = 1'b1;
        n_checks++;
        if (c !== FRAME_BITS + 1) $display("FAIL b2b_period: got %0d expected %0d", c, FRAME_BITS + 1); else n_pass++;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        n_checks++;
        if (if1.dout !== exp) $display("FAIL b2b_second_dout: got %h expected %h", if1.dout, exp); else n_pass++;
        tick();
        n_checks++;
        if (dut1.line_q !== 1'b1) $display("FAIL b2b_no_third_launch: got line %b expected 1", dut1.line_q); else n_pass++;
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        if1.din = 8'hFF; if1.start = 1'b0;
        tick();
        if1.start = 1'b1;
        repeat (4) tick();
        if1.stop = 1'b1;
        tick();
        n_checks++;
        if (dut1.line_q !== 1'b1) $display("FAIL abort_line: got %b expected 1", dut1.line_q); else n_pass++;
        if1.stop = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (if1.done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL abort_done: got done pulse expected none"); else n_pass++;
        n_checks++;
        if (if1.dout !== 8'h3C) $display("FAIL abort_dout: got %h expected 3c", if1.dout); else n_pass++;
    endtask

    task automatic test_priority();
        bit line_bad = 1'b0;
        bit done_bad = 1'b0;
        if1.din = 8'h55; if1.start = 1'b0; if1.stop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dut1.line_q !== 1'b1) line_bad = 1'b1;
            if (if1.done !== 1'b0) done_bad = 1'b1;
        end
        if1.start = 1'b1; if1.stop = 1'b0;
        tick();
        n_checks++;
        if (line_bad) $display("FAIL priority_line: got line 0 expected 1 throughout"); else n_pass++;
        n_checks++;
        if (done_bad) $display("FAIL priority_done: got done asserted expected 0 throughout"); else n_pass++;
        n_checks++;
        if (dut1.line_q !== 1'b1) $display("FAIL priority_release_line: got %b expected 1", dut1.line_q); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit seen = 1'b0;
        if1.din = 8'h5A; if1.start = 1'b0;
        tick();
        if1.start = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (if1.dout !== 8'h00) $display("FAIL midrst_dout: got %h expected 00", if1.dout); else n_pass++;
        n_checks++;
        if (dut1.line_q !== 1'b1) $display("FAIL midrst_line: got %b expected 1", dut1.line_q); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if1.done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL midrst_done: got done pulse expected none"); else n_pass++;
    endtask

    task automatic test_cpb4_odd();
        logic [7:0] d = 8'h0F;
        logic [7:0] exp;
        int         bad_k = -1;
        logic       bad_v = 1'b0;
        int         c;
        if4.din = d; if4.start = 1'b0;
        sb_q.push_back(d);
        tick();
        if4.start = 1'b1;
        for (int k = 0; k < FRAME_BITS * 4; k++) begin
            if (k > 0) tick();
            if (bad_k < 0 && dut4.line_q !== exp_line_bit(d, k / 4, 1'b1)) begin
                bad_k = k;
                bad_v = dut4.line_q;
            end
        end
        n_checks++;
        if (bad_k >= 0)
            $display("FAIL cpb4_line cycle %0d: got %b expected %b", bad_k, bad_v, exp_line_bit(d, bad_k / 4, 1'b1));
        else n_pass++;
        wait_done(4, 20, c);
        n_checks++;
        if (c < 0 || (FRAME_BITS * 4 - 1 + c) !== FRAME_BITS * 4)
            $display("FAIL cpb4_latency: got %0d expected %0d", (c < 0) ? -1 : FRAME_BITS * 4 - 1 + c, FRAME_BITS * 4);
        else n_pass++;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        n_checks++;
        if (if4.dout !== exp) $display("FAIL cpb4_dout: got %h expected %h", if4.dout, exp); else n_pass++;
        n_checks++;
        if (sb_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_priority();
        test_reset_mid_frame();
        test_cpb4_odd();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
